// File: rtl/dm_cache_responder.sv
// Direct-mapped read-only cache: 1024 lines x 4 words, block fill on miss, saturating hit counter.
// Optional build macro MISS_COUNT_EN adds a saturating miss_count output.
module dm_cache_responder #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 10,
  parameter int OFFSET_W = 2,
  parameter int HIT_W    = 14
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cache_read,
  input  logic                                 cache_write,
  input  logic [ADDR_W-1:0]                    address,
  output logic                                 cache_ready,
  output logic [DATA_W-1:0]                    cache_data,
  output logic [HIT_W-1:0]                     hit_count,
`ifdef MISS_COUNT_EN
  output logic [HIT_W-1:0]                     miss_count,
`endif
  output logic                                 mem_read,
  output logic [ADDR_W-OFFSET_W-1:0]           mem_addr,
  input  logic                                 mem_ready,
  input  logic [(1<<OFFSET_W)*DATA_W-1:0]      mem_data
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int BLK_W = (1 << OFFSET_W) * DATA_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESPOND} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   req_addr;
  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;
  logic                hit;
  logic                fill_done;
  logic                unused_write;

  logic [LINES-1:0]    valid;
  logic [TAG_W-1:0]    tag_mem [LINES];
  logic [BLK_W-1:0]    blk_mem [LINES];

  function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] c);
    return (&c) ? c : c + HIT_W'(1);
  endfunction

  function automatic logic [DATA_W-1:0] word_sel(input logic [BLK_W-1:0] blk,
                                                 input logic [OFFSET_W-1:0] off);
    return blk[off*DATA_W +: DATA_W];
  endfunction

  // Writes are not supported; the request line is deliberately ignored.
  assign unused_write = cache_write;

  assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx   = req_addr[OFFSET_W +: INDEX_W];
  assign req_off   = req_addr[OFFSET_W-1:0];
  assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign fill_done = (state == FILL) && mem_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cache_read) state_nx = LOOKUP;
      LOOKUP:  state_nx = hit ? RESPOND : FILL;
      FILL:    if (mem_ready) state_nx = RESPOND;
      RESPOND: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Request capture: address is sampled once per transaction in IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && cache_read) req_addr <= address;
  end

  // Line storage: only the valid bits are reset; tags and data are plain RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            valid <= '0;
    else if (fill_done) valid[req_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[req_idx] <= req_tag;
      blk_mem[req_idx] <= mem_data;
    end
  end

  // Response and memory-request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_ready <= 1'b0;
      cache_data  <= '0;
      hit_count   <= '0;
      mem_read    <= 1'b0;
      mem_addr    <= '0;
`ifdef MISS_COUNT_EN
      miss_count  <= '0;
`endif
    end else begin
      cache_ready <= 1'b0;
      case (state)
        LOOKUP: begin
          if (hit) begin
            cache_ready <= 1'b1;
            cache_data  <= word_sel(blk_mem[req_idx], req_off);
            hit_count   <= sat_inc(hit_count);
          end else begin
            mem_read    <= 1'b1;
            mem_addr    <= req_addr[ADDR_W-1:OFFSET_W];
`ifdef MISS_COUNT_EN
            miss_count  <= sat_inc(miss_count);
`endif
          end
        end
        FILL: begin
          if (mem_ready) begin
            cache_ready <= 1'b1;
            cache_data  <= word_sel(mem_data, req_off);
            mem_read    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_cache_responder.sv
// Self-checking bench for dm_cache_responder: randomized reads against a line-level reference model.
// Build with MISS_COUNT_EN defined to also check miss_count.
module tb_dm_cache_responder;

  logic         clk;
  logic         rst;
  logic         cache_read;
  logic         cache_write;
  logic [14:0]  address;
  logic         cache_ready;
  logic [31:0]  cache_data;
  logic [13:0]  hit_count;
`ifdef MISS_COUNT_EN
  logic [13:0]  miss_count;
`endif
  logic         mem_read;
  logic [12:0]  mem_addr;
  logic         mem_ready;
  logic [127:0] mem_data;

  int n_checks;
  int n_fail;

  // Reference model: which block each line currently holds, plus event tallies.
  bit         ref_valid [1024];
  logic [2:0] ref_tag   [1024];
  int         ref_hits;
  int         ref_misses;

  dm_cache_responder dut (
    .clk         (clk),
    .rst         (rst),
    .cache_read  (cache_read),
    .cache_write (cache_write),
    .address     (address),
    .cache_ready (cache_ready),
    .cache_data  (cache_data),
    .hit_count   (hit_count),
`ifdef MISS_COUNT_EN
    .miss_count  (miss_count),
`endif
    .mem_read    (mem_read),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_data    (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [14:0] a);
    logic [31:0] x;
    x = {17'd0, a};
    return (x * 32'h9E3779B1) ^ 32'hC3A50F1E;
  endfunction

  function automatic logic [127:0] block_of(input logic [12:0] b);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = word_of({b, 2'(k)});
    return r;
  endfunction

  function automatic bit ref_access(input logic [14:0] a);
    int idx;
    bit h;
    idx = int'(a[11:2]);
    h = ref_valid[idx] && (ref_tag[idx] == a[14:12]);
    if (h) ref_hits++;
    else begin
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = a[14:12];
      ref_misses++;
    end
    return h;
  endfunction

  function automatic int sat(input int v);
    return (v > 16383) ? 16383 : v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cache_read = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    foreach (ref_valid[i]) ref_valid[i] = 1'b0;
    ref_hits = 0; ref_misses = 0;
  endtask

  // Controller + memory driver. Starts at a falling edge and returns at the falling
  // edge where cache_ready is seen, so back-to-back calls give 3-cycle spacing.
  task automatic do_read(input logic [14:0] a, input int wait_cyc, input bit stray,
                         output bit got, output logic [31:0] data, output int fills,
                         output logic [12:0] maddr);
    int cyc, w;
    bit seen;
    got = 1'b0; data = '0; fills = 0; maddr = '0; seen = 1'b0; w = 0; cyc = 0;
    address = a; cache_read = 1'b1; cache_write = 1'($urandom_range(0, 1));
    if (stray) begin mem_ready = 1'b1; mem_data = {4{32'hDEADBEEF}}; end
    while (!got && cyc < 64) begin
      @(negedge clk); cyc++;
      mem_ready = 1'b0;
      if (cache_ready) begin
        got = 1'b1; data = cache_data;
      end else if (mem_read) begin
        if (!seen) begin seen = 1'b1; fills++; maddr = mem_addr; end
        if (w == wait_cyc) begin mem_ready = 1'b1; mem_data = block_of(mem_addr); end
        w++;
      end
    end
    cache_read = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    foreach (ref_valid[i]) ref_valid[i] = 1'b0;
    ref_hits = 0; ref_misses = 0;
    n_checks++; if (cache_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", cache_ready); end
    n_checks++; if (cache_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h required 0", cache_data); end
    n_checks++; if (hit_count !== 14'd0) begin n_fail++; $display("FAIL reset_hits: got %0d required 0", hit_count); end
    n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read: got %b required 0", mem_read); end
    n_checks++; if (mem_addr !== 13'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %0d required 0", mem_addr); end
`ifdef MISS_COUNT_EN
    n_checks++; if (miss_count !== 14'd0) begin n_fail++; $display("FAIL reset_misses: got %0d required 0", miss_count); end
`endif
  endtask

  task automatic test_cold_read();
    bit got; logic [31:0] d; int f; logic [12:0] ma;
    do_reset();
    do_read(15'd1024, 5, 1'b0, got, d, f, ma);
    void'(ref_access(15'd1024));
    n_checks++; if (!got) begin n_fail++; $display("FAIL cold_ready: no cache_ready within budget"); end
    n_checks++; if (f !== 1) begin n_fail++; $display("FAIL cold_fills: got %0d required 1", f); end
    n_checks++; if (ma !== 13'd256) begin n_fail++; $display("FAIL cold_mem_addr: got %0d required 256", ma); end
    n_checks++; if (d !== word_of(15'd1024)) begin n_fail++; $display("FAIL cold_data: got %h required %h", d, word_of(15'd1024)); end
    @(negedge clk);
    n_checks++; if (cache_ready !== 1'b0) begin n_fail++; $display("FAIL cold_pulse: got %b required 0", cache_ready); end
    n_checks++; if (cache_data !== word_of(15'd1024)) begin n_fail++; $display("FAIL cold_hold: got %h required %h", cache_data, word_of(15'd1024)); end
    n_checks++; if (hit_count !== 14'd0) begin n_fail++; $display("FAIL cold_hits: got %0d required 0", hit_count); end
  endtask

  task automatic test_sequential();
    bit got, h; logic [31:0] d; int f, tf; logic [12:0] ma;
    do_reset();
    tf = 0;
    for (int a = 1024; a <= 1027; a++) begin
      do_read(15'(a), 2, 1'b0, got, d, f, ma);
      h = ref_access(15'(a));
      tf += f;
      n_checks++;
      if (!got || d !== word_of(15'(a)) || f !== (h ? 0 : 1)) begin
        n_fail++; $display("FAIL seq_read: addr %0d got data %h fills %0d required %h fills %0d", a, d, f, word_of(15'(a)), h ? 0 : 1);
      end
    end
    n_checks++; if (tf !== 1) begin n_fail++; $display("FAIL seq_fills: got %0d required 1", tf); end
    n_checks++; if (hit_count !== 14'd3) begin n_fail++; $display("FAIL seq_hits: got %0d required 3", hit_count); end
  endtask

  task automatic test_sweep();
    bit got, h; logic [31:0] d; int f, tf; logic [12:0] ma;
    do_reset();
    tf = 0;
    for (int a = 1024; a <= 9215; a++) begin
      do_read(15'(a), 0, 1'b0, got, d, f, ma);
      h = ref_access(15'(a));
      tf += f;
      n_checks++;
      if (!got || d !== word_of(15'(a)) || f !== (h ? 0 : 1)) begin
        n_fail++; $display("FAIL sweep_read: addr %0d got data %h fills %0d required %h fills %0d", a, d, f, word_of(15'(a)), h ? 0 : 1);
      end
    end
    n_checks++; if (tf !== 2048) begin n_fail++; $display("FAIL sweep_fills: got %0d required 2048", tf); end
    n_checks++; if (hit_count !== 14'd6144) begin n_fail++; $display("FAIL sweep_hits: got %0d required 6144", hit_count); end
  endtask

  task automatic test_conflict();
    bit got; logic [31:0] d; int f, tf; logic [12:0] ma;
    logic [14:0] seq [3];
    seq[0] = 15'd0; seq[1] = 15'd4096; seq[2] = 15'd0;
    do_reset();
    tf = 0;
    for (int i = 0; i < 3; i++) begin
      do_read(seq[i], 1, 1'b0, got, d, f, ma);
      void'(ref_access(seq[i]));
      tf += f;
      n_checks++;
      if (!got || d !== word_of(seq[i]) || ma !== seq[i][14:2]) begin
        n_fail++; $display("FAIL conflict_read: addr %0d got data %h mem_addr %0d required %h mem_addr %0d", seq[i], d, ma, word_of(seq[i]), seq[i][14:2]);
      end
    end
    n_checks++; if (tf !== 3) begin n_fail++; $display("FAIL conflict_fills: got %0d required 3", tf); end
    n_checks++; if (hit_count !== 14'd0) begin n_fail++; $display("FAIL conflict_hits: got %0d required 0", hit_count); end
  endtask

  task automatic test_random();
    bit got, h; logic [31:0] d; int f; logic [12:0] ma;
    logic [14:0] a;
    logic [9:0] idx_set [4];
    idx_set[0] = 10'd0; idx_set[1] = 10'd1; idx_set[2] = 10'd2; idx_set[3] = 10'd1023;
    do_reset();
    for (int i = 0; i < 250; i++) begin
      if (i == 100)      a = 15'd32767;
      else if (i == 101) a = 15'd0;
      else begin
        a[14:12] = 3'($urandom_range(0, 7));
        a[11:2]  = idx_set[$urandom_range(0, 3)];
        a[1:0]   = 2'($urandom_range(0, 3));
      end
      do_read(a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got, d, f, ma);
      h = ref_access(a);
      n_checks++;
      if (!got || d !== word_of(a) || f !== (h ? 0 : 1)) begin
        n_fail++; $display("FAIL rand_read: addr %0d got data %h fills %0d required %h fills %0d", a, d, f, word_of(a), h ? 0 : 1);
      end
    end
    n_checks++; if (int'(hit_count) !== sat(ref_hits)) begin n_fail++; $display("FAIL rand_hits: got %0d required %0d", hit_count, sat(ref_hits)); end
`ifdef MISS_COUNT_EN
    n_checks++; if (int'(miss_count) !== sat(ref_misses)) begin n_fail++; $display("FAIL rand_misses: got %0d required %0d", miss_count, sat(ref_misses)); end
`endif
  endtask

  task automatic test_saturation();
    bit got; logic [31:0] d; int f, tf, bad; logic [12:0] ma;
    do_reset();
    tf = 0; bad = 0;
    for (int i = 0; i < 16386; i++) begin
      do_read(15'd5, 0, 1'b0, got, d, f, ma);
      void'(ref_access(15'd5));
      tf += f;
      if (!got || d !== word_of(15'd5)) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL sat_data: got %0d bad reads required 0", bad); end
    n_checks++; if (tf !== 1) begin n_fail++; $display("FAIL sat_fills: got %0d required 1", tf); end
    n_checks++; if (hit_count !== 14'd16383) begin n_fail++; $display("FAIL sat_hits: got %0d required 16383", hit_count); end
    n_checks++; if (int'(hit_count) !== sat(ref_hits)) begin n_fail++; $display("FAIL sat_hits_model: got %0d required %0d", hit_count, sat(ref_hits)); end
`ifdef MISS_COUNT_EN
    n_checks++; if (miss_count !== 14'd1) begin n_fail++; $display("FAIL sat_misses: got %0d required 1", miss_count); end
`endif
  endtask

  task automatic test_reset_fill();
    bit got, seen; logic [31:0] d; int f, pulses; logic [12:0] ma;
    do_reset();
    @(negedge clk);
    address = 15'd700; cache_read = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_read) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rf_mem_read: no mem_read within budget"); end
    rst = 1'b1; cache_read = 1'b0;
    #1;
    n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL rf_async_drop: got %b required 0", mem_read); end
    @(negedge clk);
    rst = 1'b0;
    foreach (ref_valid[i]) ref_valid[i] = 1'b0;
    ref_hits = 0; ref_misses = 0;
    repeat (2) @(negedge clk);
    mem_ready = 1'b1; mem_data = block_of(13'd175);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (cache_ready) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rf_no_ready: got %0d pulses required 0", pulses); end
    n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL rf_mem_read_low: got %b required 0", mem_read); end
    do_read(15'd700, 1, 1'b0, got, d, f, ma);
    void'(ref_access(15'd700));
    n_checks++; if (f !== 1) begin n_fail++; $display("FAIL rf_remiss: got %0d fills required 1", f); end
    n_checks++; if (!got || d !== word_of(15'd700)) begin n_fail++; $display("FAIL rf_data: got %h required %h", d, word_of(15'd700)); end
    n_checks++; if (hit_count !== 14'd0) begin n_fail++; $display("FAIL rf_hits: got %0d required 0", hit_count); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; cache_read = 1'b0; cache_write = 1'b0; address = '0;
    mem_ready = 1'b0; mem_data = '0;
    test_reset();
    test_cold_read();
    test_sequential();
    test_conflict();
    test_random();
    test_reset_fill();
    test_sweep();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_cache_responder.md
Name: dm_cache_responder

Overview:
Direct-mapped, read-only cache that sits between the cache controller (initiator) and main memory. It answers the controller's cache_read/address requests with a one-cycle cache_ready pulse and data. It fills a whole block from memory on a miss and keeps a saturating hit counter for hit-rate measurement.

Parameters:
ADDR_W, 15, word address width; address split is tag[14:12], index[11:2], offset[1:0].
DATA_W, 32, word width.
INDEX_W, 10, index bits; 1024 lines.
OFFSET_W, 2, offset bits; 4 words per block.
HIT_W, 14, hit counter width.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  reset; asynchronous, active-high.
cache_read  in  1  read request; level, held by the controller until cache_ready.
cache_write  in  1  write request; not supported; ignored in every state.
address  in  ADDR_W  word address; stable while cache_read is high and before cache_ready.
cache_ready  out  1  registered one-cycle pulse; cache_data is valid in the same cycle.
cache_data  out  DATA_W  read data; registered; holds its last value between pulses.
hit_count  out  HIT_W  saturating count of hits since reset.
mem_read  out  1  block fetch request; level, held until mem_ready.
mem_addr  out  ADDR_W-OFFSET_W  block address {tag, index}.
mem_ready  in  1  one-cycle strobe; mem_data is valid in the same cycle.
mem_data  in  4*DATA_W  block data; word k occupies bits [32k+31:32k].

Behaviour:
- Storage: per line, a valid bit, a 3-bit tag and a 4-word data block.
- Reset clears all 1024 valid bits. Data and tag arrays are not reset.
- Reset values: cache_ready=0, cache_data=0, hit_count=0, mem_read=0, mem_addr=0, state=IDLE.
- IDLE: if cache_read=1 at a rising edge, latch address into req_addr and go to LOOKUP. Otherwise stay.
- LOOKUP, hit (valid[index] && tag==req_tag):
  - cache_data <= word[offset]; cache_ready <= 1; go to RESPOND.
  - hit_count increments by 1, saturating at 16383. No wrap.
- LOOKUP, miss: mem_read <= 1; mem_addr <= req_addr[14:2]; go to FILL.
- FILL: wait any number of cycles for mem_ready. On mem_ready:
  - write mem_data into the line; set tag and valid.
  - cache_data <= mem_data word[offset]; cache_ready <= 1; mem_read <= 0; go to RESPOND.
  - A miss is never counted as a hit.
- RESPOND: cache_ready <= 0 at the next edge; go to IDLE. The controller advances address on that same edge, and IDLE samples the new address one edge later.
- Latency from the cache_read sampling edge: hit = cache_ready high in the 2nd cycle; miss = 2 cycles + memory wait.
- Minimum request-to-request spacing: 3 cycles.
- cache_read dropping outside IDLE has no effect; the transaction completes.
- mem_ready outside FILL is ignored.
- Miss on a valid line with a different tag: replace the line (eviction). No write-back is needed because the cache is read-only.
- Reset mid-FILL: mem_read drops immediately, state goes to IDLE, all lines are invalid, and a late mem_ready is ignored.
- Address wrap: 32767 followed by 0 is legal; these are plain independent accesses.

Optional Feature:
MISS_COUNT_EN
- Defined: adds output miss_count [HIT_W-1:0]. Reset value 0. Increments once per LOOKUP miss and saturates at 16383.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Cold read of address 1024 with memory returning after 5 cycles:
  - mem_addr=256; cache_ready pulses once with word 0 of the block.
  - hit_count stays 0.
- Sequential reads of 1024..1027 after a cold reset -> 1 fill, then 3 hits; hit_count=3.
- Reads 1024..9215 (8192 accesses) with zero-wait memory -> 2048 fills; hit_count=6144 (the controller's hit rate is 75).
- Conflict sequence 0, 4096, 0 (same index 0, tags 0/1/0) -> three misses, three mem_read requests, hit_count=0.
- Saturation:
  - Read address 5 twice to warm the line, then re-read it 16384 more times; hit_count holds at 16383.
  - With MISS_COUNT_EN defined, miss_count=1.
- Assert rst while in FILL, then pulse mem_ready 2 cycles later:
  - No cache_ready; mem_read=0; the line remains invalid.
  - The next read of the same address misses again.
